// File: rtl/mips_cpu.sv
// Minimal single-cycle MIPS32 integer core: fetch from an external ROM,
// execute ALU/immediate instructions, write back to a 32x32 register file.

module MipsGprFile (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  i_rsAddr,
    input  logic [4:0]  i_rtAddr,
    output logic [31:0] o_rsData,
    output logic [31:0] o_rtData,
    input  logic        i_writeEn,
    input  logic [4:0]  i_writeAddr,
    input  logic [31:0] i_writeData
);
    logic [31:0] regs [0:31];

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_writeEn && (i_writeAddr != 5'd0)) begin
            regs[i_writeAddr] <= i_writeData;
        end
    end

    assign o_rsData = regs[i_rsAddr];
    assign o_rtData = regs[i_rtAddr];
endmodule

module mips_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rom_data,
    output logic [31:0] rom_addr,
    output logic        rom_chip_enable
);
    logic [31:0] r_pc;
    logic        r_chipEnable;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sa;
    logic [5:0]  w_funct;
    logic [31:0] w_immSext;
    logic [31:0] w_immZext;
    logic [31:0] w_rsData;
    logic [31:0] w_rtData;
    logic [31:0] w_result;
    logic [4:0]  w_dest;
    logic        w_valid;

    assign w_opcode  = rom_data[31:26];
    assign w_rs      = rom_data[25:21];
    assign w_rt      = rom_data[20:16];
    assign w_rd      = rom_data[15:11];
    assign w_sa      = rom_data[10:6];
    assign w_funct   = rom_data[5:0];
    assign w_immSext = {{16{rom_data[15]}}, rom_data[15:0]};
    assign w_immZext = {16'h0000, rom_data[15:0]};

    // The first enabled edge only raises the chip enable; the PC starts moving after that.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_chipEnable <= 1'b0;
        end else if (r_chipEnable) begin
            r_pc <= r_pc + 32'd4;
        end else begin
            r_chipEnable <= 1'b1;
        end
    end

    always_comb begin
        w_result = '0;
        w_dest   = w_rt;
        w_valid  = 1'b1;
        if (w_opcode == 6'h00) begin
            w_dest = w_rd;
            case (w_funct)
                6'h00:   w_result = w_rtData << w_sa;
                6'h02:   w_result = w_rtData >> w_sa;
                6'h03:   w_result = $unsigned($signed(w_rtData) >>> w_sa);
                6'h04:   w_result = w_rtData << w_rsData[4:0];
                6'h06:   w_result = w_rtData >> w_rsData[4:0];
                6'h07:   w_result = $unsigned($signed(w_rtData) >>> w_rsData[4:0]);
                6'h21:   w_result = w_rsData + w_rtData;
                6'h23:   w_result = w_rsData - w_rtData;
                6'h24:   w_result = w_rsData & w_rtData;
                6'h25:   w_result = w_rsData | w_rtData;
                6'h26:   w_result = w_rsData ^ w_rtData;
                6'h27:   w_result = ~(w_rsData | w_rtData);
                6'h2A:   w_result = {31'd0, $signed(w_rsData) < $signed(w_rtData)};
                6'h2B:   w_result = {31'd0, w_rsData < w_rtData};
                default: w_valid  = 1'b0;
            endcase
        end else begin
            case (w_opcode)
                6'h09:   w_result = w_rsData + w_immSext;
                6'h0A:   w_result = {31'd0, $signed(w_rsData) < $signed(w_immSext)};
                6'h0B:   w_result = {31'd0, w_rsData < w_immSext};
                6'h0C:   w_result = w_rsData & w_immZext;
                6'h0D:   w_result = w_rsData | w_immZext;
                6'h0E:   w_result = w_rsData ^ w_immZext;
                6'h0F:   w_result = {rom_data[15:0], 16'h0000};
                default: w_valid  = 1'b0;
            endcase
        end
    end

    MipsGprFile gpr_file_instance (
        .clock       (clock),
        .reset       (reset),
        .i_rsAddr    (w_rs),
        .i_rtAddr    (w_rt),
        .o_rsData    (w_rsData),
        .o_rtData    (w_rtData),
        .i_writeEn   (r_chipEnable && w_valid),
        .i_writeAddr (w_dest),
        .i_writeData (w_result)
    );

    assign rom_addr        = r_pc;
    assign rom_chip_enable = r_chipEnable;
endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed programs plus random instruction
// streams, compared every cycle against an architectural model of the core.

module tb_mips_cpu;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] romData;
    logic [31:0] romAddr;
    logic        romChipEnable;

    logic [31:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    // Architectural model state
    logic [31:0] mPc;
    logic        mEn;
    logic [31:0] mRegs [0:31];

    assign romData = romChipEnable ? mem[romAddr[7:2]] : 32'h0;

    mips_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .rom_data        (romData),
        .rom_addr        (romAddr),
        .rom_chip_enable (romChipEnable)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("rom_addr", romAddr, mPc);
        checkOutput("chip_enable", {31'd0, romChipEnable}, {31'd0, mEn});
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("r%0d", i), dut.gpr_file_instance.regs[i], mRegs[i]);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0;
        mEn = 1'b0;
        for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
    endtask

    // Architectural effect of one instruction word on the register state
    task automatic modelExec(input logic [31:0] ins);
        int          op, fn, rs, rt, rd, sa, dest;
        logic [31:0] a, b, se, ze, v;
        op = int'(ins[31:26]);
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        sa = int'(ins[10:6]);
        fn = int'(ins[5:0]);
        a  = mRegs[rs];
        b  = mRegs[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        v  = 32'h0;
        dest = -1;
        if (op == 0) begin
            dest = rd;
            case (fn)
                'h00: v = b << sa;
                'h02: v = b >> sa;
                'h03: v = $unsigned($signed(b) >>> sa);
                'h04: v = b << a[4:0];
                'h06: v = b >> a[4:0];
                'h07: v = $unsigned($signed(b) >>> a[4:0]);
                'h21: v = a + b;
                'h23: v = a - b;
                'h24: v = a & b;
                'h25: v = a | b;
                'h26: v = a ^ b;
                'h27: v = ~(a | b);
                'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                'h2B: v = (a < b) ? 32'd1 : 32'd0;
                default: dest = -1;
            endcase
        end else begin
            dest = rt;
            case (op)
                'h09: v = a + se;
                'h0A: v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                'h0B: v = (a < se) ? 32'd1 : 32'd0;
                'h0C: v = a & ze;
                'h0D: v = a | ze;
                'h0E: v = a ^ ze;
                'h0F: v = {ins[15:0], 16'h0};
                default: dest = -1;
            endcase
        end
        if (dest > 0) mRegs[dest] = v;
    endtask

    // Called at a falling edge: advance the model, let one rising edge pass, compare.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            if (mEn) begin
                modelExec(mem[mPc[7:2]]);
                mPc = mPc + 32'd4;
            end else begin
                mEn = 1'b1;
            end
            @(posedge clock);
            #1;
            checkState();
            @(negedge clock);
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [5:0] functs [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                                    6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        logic [5:0] iops [7] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        int k;
        k   = int'($urandom_range(0, 19));
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sa  = 5'($urandom);
        imm = 16'($urandom);
        if (k < 10) return {6'h00, rs, rt, rd, sa, functs[$urandom_range(0, 13)]};
        if (k < 18) return {iops[$urandom_range(0, 6)], rs, rt, imm};
        return $urandom;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h34011100;
        mem[1]  = 32'h3C02ABCD;
        mem[2]  = 32'h2403FFFF;
        mem[3]  = 32'h340100F0;
        mem[4]  = 32'h00212025;
        mem[5]  = 32'h00202827;
        mem[6]  = 32'h00033103;
        mem[7]  = 32'h00033902;
        mem[8]  = 32'h0060402A;
        mem[9]  = 32'h0060482B;
        mem[10] = 32'h34001234;
        mem[11] = 32'hFC000000;
        modelReset();

        repeat (3) @(negedge clock);
        checkState();
        reset = 1'b1;

        applyStimulus(1);
        applyStimulus(3);
        checkOutput("ori_r1", dut.gpr_file_instance.regs[1], 32'h00001100);
        checkOutput("lui_r2", dut.gpr_file_instance.regs[2], 32'hABCD0000);
        checkOutput("addiu_r3", dut.gpr_file_instance.regs[3], 32'hFFFFFFFF);
        applyStimulus(9);
        checkOutput("or_r4", dut.gpr_file_instance.regs[4], 32'h000000F0);
        checkOutput("nor_r5", dut.gpr_file_instance.regs[5], 32'hFFFFFF0F);
        checkOutput("sra_r6", dut.gpr_file_instance.regs[6], 32'hFFFFFFFF);
        checkOutput("srl_r7", dut.gpr_file_instance.regs[7], 32'h0FFFFFFF);
        checkOutput("slt_r8", dut.gpr_file_instance.regs[8], 32'h00000001);
        checkOutput("sltu_r9", dut.gpr_file_instance.regs[9], 32'h00000000);
        checkOutput("r0_zero", dut.gpr_file_instance.regs[0], 32'h00000000);
        checkOutput("pc_after_nops", romAddr, 32'd48);

        // Asynchronous reset between edges after five instructions
        reset = 1'b0;
        #1;
        modelReset();
        checkState();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        applyStimulus(6);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_pc", romAddr, 32'h0);
        checkOutput("midrst_en", {31'd0, romChipEnable}, 32'h0);
        modelReset();
        checkState();
        @(negedge clock);
        checkState();
        reset = 1'b1;
        applyStimulus(4);
        checkOutput("rerun_r2", dut.gpr_file_instance.regs[2], 32'hABCD0000);

        // Random instruction streams from a fresh reset
        for (int t = 0; t < 4; t++) begin
            reset = 1'b0;
            for (int i = 0; i < 64; i++) mem[i] = randInstr();
            modelReset();
            @(negedge clock);
            checkState();
            reset = 1'b1;
            applyStimulus(90);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
